// File: rtl/data_ram_port_arbiter_pkg.sv
// Shared types for the hash-table data RAM port arbiter.
// Table geometry, RAM word type and arbiter defaults.
package data_ram_port_arbiter_pkg;

   localparam int TABLE_ADDR_WIDTH = 10;
   localparam int ENGINES_CNT_DEF  = 3;
   localparam int STARVE_LIMIT_DEF = 4;

   typedef logic [31:0] ram_data_t;
   typedef logic [$clog2(ENGINES_CNT_DEF)-1:0] eng_id_t;

endpackage

// File: rtl/data_ram_port_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, pointer advances on accepted grant.
// Search starts one past the last winner.
module rr_arbiter #(
   parameter int N    = 3,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req_i,
   input  logic            advance_i,
   output logic [N-1:0]    gnt_o,
   output logic [ID_W-1:0] idx_o
);

   logic [ID_W-1:0] ptr;
   logic            found;
   int              j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int off = 1; off <= N; off++) begin
         j = (int'(ptr) + off) % N;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = ID_W'(j);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr <= ID_W'(N - 1);
      end else if (advance_i && found) begin
         ptr <= idx_o;
      end
   end

endmodule

// File: rtl/data_ram_port_arbiter.sv
// Single-port data RAM scheduler: round-robin reads, write priority
// with read-starvation protection, and per-engine read-data strobes.
module data_ram_port_arbiter
   import data_ram_port_arbiter_pkg::*;
#(
   parameter int ENGINES_CNT  = ENGINES_CNT_DEF,
   parameter int RAM_LATENCY  = 2,
   parameter int A_WIDTH      = TABLE_ADDR_WIDTH,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [ENGINES_CNT-1:0]            rd_req_i,
   input  logic [ENGINES_CNT-1:0][A_WIDTH-1:0] rd_addr_i,
   output logic [ENGINES_CNT-1:0]            rd_gnt_o,
   output logic [ENGINES_CNT-1:0]            rd_data_val_o,
   input  logic                              wr_req_i,
   input  logic [A_WIDTH-1:0]                wr_addr_i,
   input  ram_data_t                         wr_data_i,
   output logic                              wr_gnt_o,
   output logic [A_WIDTH-1:0]                ram_addr_o,
   output logic                              ram_en_o,
   output logic                              ram_we_o,
   output ram_data_t                         ram_wdata_o,
   output logic                              rd_in_flight_o
);

   localparam int ID_W = $clog2(ENGINES_CNT);
   localparam int SW   = $clog2(STARVE_LIMIT + 1);

   logic [ENGINES_CNT-1:0] arb_gnt;
   logic [ID_W-1:0]        rd_idx;
   logic [SW-1:0]          starve_cnt;
   logic                   rd_pend;
   logic                   force_rd;
   logic                   wr_win;
   logic                   rd_en;

   logic [RAM_LATENCY-1:0]           pipe_val;
   logic [RAM_LATENCY-1:0][ID_W-1:0] pipe_id;

   assign rd_pend  = |rd_req_i;
   assign force_rd = (starve_cnt == SW'(STARVE_LIMIT)) && rd_pend;
   // Grants are suppressed while reset is held so every output reads 0.
   assign wr_win   = wr_req_i && !force_rd && !rst_i;
   assign rd_en    = rd_pend && !wr_win && !rst_i;

   rr_arbiter #(
      .N    (ENGINES_CNT),
      .ID_W (ID_W)
   ) u_rr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (rd_req_i),
      .advance_i (rd_en),
      .gnt_o     (arb_gnt),
      .idx_o     (rd_idx)
   );

   assign rd_gnt_o = rd_en ? arb_gnt : '0;
   assign wr_gnt_o = wr_win;
   assign ram_en_o = rd_en || wr_win;

   always_comb begin
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_wdata_o = '0;
      if (wr_win) begin
         ram_addr_o  = wr_addr_i;
         ram_we_o    = 1'b1;
         ram_wdata_o = wr_data_i;
      end else if (rd_en) begin
         ram_addr_o = rd_addr_i[rd_idx];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (rd_en || !rd_pend) begin
         starve_cnt <= '0;
      end else if (wr_win && starve_cnt != SW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_val <= '0;
         pipe_id  <= '0;
      end else begin
         pipe_val[0] <= rd_en;
         pipe_id[0]  <= rd_en ? rd_idx : '0;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            pipe_val[i] <= pipe_val[i-1];
            pipe_id[i]  <= pipe_id[i-1];
         end
      end
   end

   assign rd_data_val_o = pipe_val[RAM_LATENCY-1]
                        ? (ENGINES_CNT'(1) << pipe_id[RAM_LATENCY-1])
                        : '0;
   assign rd_in_flight_o = |pipe_val;

endmodule

// File: tb/tb_data_ram_port_arbiter.sv
// Scoreboard bench for data_ram_port_arbiter (N=3, latency 2, limit 4).
// Stimulus pushes expected grants/strobes; a negedge monitor pops them.
module tb_data_ram_port_arbiter;
   import data_ram_port_arbiter_pkg::*;

   localparam int N  = 3;
   localparam int AW = TABLE_ADDR_WIDTH;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic [N-1:0]        rd_req_i = '0;
   logic [N-1:0][AW-1:0] rd_addr_i = '0;
   logic [N-1:0]        rd_gnt_o;
   logic [N-1:0]        rd_data_val_o;
   logic                wr_req_i = 1'b0;
   logic [AW-1:0]       wr_addr_i = '0;
   ram_data_t           wr_data_i = '0;
   logic                wr_gnt_o;
   logic [AW-1:0]       ram_addr_o;
   logic                ram_en_o;
   logic                ram_we_o;
   ram_data_t           ram_wdata_o;
   logic                rd_in_flight_o;

   data_ram_port_arbiter #(
      .ENGINES_CNT  (N),
      .RAM_LATENCY  (2),
      .A_WIDTH      (AW),
      .STARVE_LIMIT (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rd_req_i       (rd_req_i),
      .rd_addr_i      (rd_addr_i),
      .rd_gnt_o       (rd_gnt_o),
      .rd_data_val_o  (rd_data_val_o),
      .wr_req_i       (wr_req_i),
      .wr_addr_i      (wr_addr_i),
      .wr_data_i      (wr_data_i),
      .wr_gnt_o       (wr_gnt_o),
      .ram_addr_o     (ram_addr_o),
      .ram_en_o       (ram_en_o),
      .ram_we_o       (ram_we_o),
      .ram_wdata_o    (ram_wdata_o),
      .rd_in_flight_o (rd_in_flight_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [N-1:0]  rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic          we;
      ram_data_t     wd;
      int            cyc;
   } gexp_t;

   typedef struct {
      logic [N-1:0] val;
      int           cyc;
   } sexp_t;

   gexp_t gq[$];
   sexp_t sq[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic exp_rd(input int eng, input logic [AW-1:0] a,
                         input bit strobe);
      gexp_t g;
      sexp_t s;
      g.rd = N'(1) << eng;
      g.wr = 1'b0;
      g.addr = a;
      g.we = 1'b0;
      g.wd = '0;
      g.cyc = cyc;
      gq.push_back(g);
      if (strobe) begin
         s.val = N'(1) << eng;
         s.cyc = cyc + 2;
         sq.push_back(s);
      end
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input ram_data_t d);
      gexp_t g;
      g.rd = '0;
      g.wr = 1'b1;
      g.addr = a;
      g.we = 1'b1;
      g.wd = d;
      g.cyc = cyc;
      gq.push_back(g);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every RAM access and every strobe must match the queue head.
   always @(negedge clk_i) begin
      if (ram_en_o) begin
         if (gq.size() == 0) begin
            chk("unexpected_access", {rd_gnt_o, wr_gnt_o}, 0);
         end else begin
            gexp_t g;
            g = gq.pop_front();
            chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
            chk("rd_gnt", rd_gnt_o, g.rd);
            chk("wr_gnt", wr_gnt_o, g.wr);
            chk("ram_addr", ram_addr_o, g.addr);
            chk("ram_we", ram_we_o, g.we);
            chk("ram_wdata", ram_wdata_o, g.wd);
         end
      end else begin
         if (rd_gnt_o != 0 || wr_gnt_o)
            chk("gnt_without_en", {rd_gnt_o, wr_gnt_o}, 0);
      end
      if (rd_data_val_o != 0) begin
         if (sq.size() == 0) begin
            chk("unexpected_strobe", rd_data_val_o, 0);
         end else begin
            sexp_t s;
            s = sq.pop_front();
            chk("strobe_cycle", 64'(cyc), 64'(s.cyc));
            chk("strobe_val", rd_data_val_o, s.val);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_gnt"}, rd_gnt_o, 0);
      chk({tag, "_wr_gnt"}, wr_gnt_o, 0);
      chk({tag, "_ram_en"}, ram_en_o, 0);
      chk({tag, "_ram_we"}, ram_we_o, 0);
      chk({tag, "_ram_addr"}, ram_addr_o, 0);
      chk({tag, "_ram_wdata"}, ram_wdata_o, 0);
      chk({tag, "_rd_val"}, rd_data_val_o, 0);
      chk({tag, "_in_flight"}, rd_in_flight_o, 0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      rd_req_i = '0;
      wr_req_i = 1'b0;
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with every requester active: nothing may leak out.
      rd_req_i = 3'b111;
      wr_req_i = 1'b1;
      wr_addr_i = 10'h155;
      wr_data_i = 32'hAAAA5555;
      tick();
      tick();
      chk_all_zero("reset");
      rst_i = 1'b0;
      rd_req_i = '0;
      wr_req_i = 1'b0;
      tick();

      // Single read on engine 1.
      rd_addr_i[1] = 10'h015;
      rd_req_i = 3'b010;
      exp_rd(1, 10'h015, 1'b1);
      chk("single_inflight_t0", rd_in_flight_o, 1'b0);
      tick();
      rd_req_i = '0;
      chk("single_inflight_t1", rd_in_flight_o, 1'b1);
      tick();
      chk("single_inflight_t2", rd_in_flight_o, 1'b1);
      tick();
      chk("single_inflight_t3", rd_in_flight_o, 1'b0);

      // All engines requesting from reset: 0,1,2,0,1,2.
      do_reset();
      rd_addr_i[0] = 10'h100;
      rd_addr_i[1] = 10'h101;
      rd_addr_i[2] = 10'h102;
      rd_req_i = 3'b111;
      for (int k = 0; k < 6; k++) begin
         exp_rd(k % 3, 10'h100 + 10'(k % 3), 1'b1);
         tick();
      end
      rd_req_i = '0;
      tick();
      tick();

      // Write priority with forced read after four write grants.
      wr_addr_i = 10'h3AA;
      wr_data_i = 32'hDEADBEEF;
      wr_req_i = 1'b1;
      rd_addr_i[1] = 10'h021;
      rd_req_i = 3'b010;
      for (int k = 0; k < 4; k++) begin
         exp_wr(10'h3AA, 32'hDEADBEEF);
         tick();
      end
      exp_rd(1, 10'h021, 1'b1);
      tick();
      rd_req_i = '0;
      exp_wr(10'h3AA, 32'hDEADBEEF);
      tick();
      wr_req_i = 1'b0;
      tick();
      tick();

      // Pointer holds through write-only cycles.
      rd_addr_i[2] = 10'h0C2;
      rd_req_i = 3'b100;
      exp_rd(2, 10'h0C2, 1'b1);
      tick();
      rd_req_i = '0;
      wr_addr_i = 10'h007;
      wr_data_i = 32'h12345678;
      wr_req_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_wr(10'h007, 32'h12345678);
         tick();
      end
      wr_req_i = 1'b0;
      rd_addr_i[0] = 10'h0A0;
      rd_req_i = 3'b111;
      exp_rd(0, 10'h0A0, 1'b1);
      tick();
      rd_req_i = '0;
      tick();
      tick();

      // Dropped read pulse while a write wins: no side effects.
      wr_addr_i = 10'h2F0;
      wr_data_i = 32'h0BADF00D;
      wr_req_i = 1'b1;
      rd_req_i = 3'b001;
      exp_wr(10'h2F0, 32'h0BADF00D);
      chk("dropped_no_rd_gnt", rd_gnt_o, 0);
      tick();
      wr_req_i = 1'b0;
      rd_req_i = '0;
      tick();
      rd_addr_i[1] = 10'h0B1;
      rd_req_i = 3'b111;
      exp_rd(1, 10'h0B1, 1'b1);
      tick();
      rd_req_i = '0;
      tick();
      tick();

      // Reset while a read is in flight: its strobe must vanish.
      rd_addr_i[2] = 10'h0D2;
      rd_req_i = 3'b100;
      exp_rd(2, 10'h0D2, 1'b0);
      tick();
      rd_req_i = 3'b011;
      wr_req_i = 1'b1;
      rst_i = 1'b1;
      #1;
      chk_all_zero("midrst_t1");
      tick();
      chk("midrst_t2_val", rd_data_val_o, 0);
      chk("midrst_t2_inflight", rd_in_flight_o, 1'b0);
      rd_req_i = '0;
      wr_req_i = 1'b0;
      rst_i = 1'b0;
      tick();
      tick();
      tick();

      chk("grant_queue_empty", 64'(gq.size()), 0);
      chk("strobe_queue_empty", 64'(sq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_ram_port_arbiter.md
Name: data_ram_port_arbiter

Overview:
- Schedules the single physical port of the hash-table data RAM between ENGINES_CNT search-engine read requesters and one write/update requester.
- Replaces fixed rotating read slots and an OR-style address mux with demand-driven round-robin read arbitration.
- Adds write-priority with read-starvation protection.
- Tracks each granted read through the RAM pipeline and returns a per-requester data-valid strobe.

Parameters:
- ENGINES_CNT, 3, number of read requesters (>=2).
- RAM_LATENCY, 2, cycles from ram_en_o sample to rd_data valid at the RAM output (>=1).
- A_WIDTH, TABLE_ADDR_WIDTH, RAM address width.
- STARVE_LIMIT, 4, consecutive cycles with a pending read blocked by writes before one read is forced (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- rd_req_i  in  ENGINES_CNT  per-engine read request; held with address until granted.
- rd_addr_i  in  ENGINES_CNT x A_WIDTH  per-engine read address.
- rd_gnt_o  out  ENGINES_CNT  one-hot read grant, same cycle as accepted request.
- rd_data_val_o  out  ENGINES_CNT  one-hot strobe: shared RAM read data belongs to engine i this cycle.
- wr_req_i  in  1  write request; held with address/data until granted.
- wr_addr_i  in  A_WIDTH  write address.
- wr_data_i  in  ram_data_t  write data.
- wr_gnt_o  out  1  write grant.
- ram_addr_o  out  A_WIDTH  RAM address.
- ram_en_o  out  1  RAM access enable.
- ram_we_o  out  1  RAM write enable (1 = write, 0 = read).
- ram_wdata_o  out  ram_data_t  RAM write data.
- rd_in_flight_o  out  1  at least one granted read has not yet produced its strobe.

Behaviour:
- Reset values: all outputs 0. RR pointer = ENGINES_CNT-1, so engine 0 wins first. Starvation counter = 0. Latency pipeline cleared.
- Grant path is combinational from the requests (req -> gnt in the same cycle). At most one grant per cycle across rd_gnt_o and wr_gnt_o.
- Port drive: ram_en_o = |rd_gnt_o | wr_gnt_o. ram_addr_o, ram_we_o and ram_wdata_o come from the granted source. With no grant: addr = 0, we = 0, wdata = 0.
- Priority:
  - wr_req_i wins unless starve_cnt == STARVE_LIMIT and any rd_req_i is pending. In that case one read is granted and the write waits.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when a write is granted while any read is pending.
  - Clears on any read grant, or on any cycle with no read pending.
- Read round-robin:
  - Search starts at pointer+1 modulo ENGINES_CNT and the first requesting index wins.
  - Pointer updates to the winner only on a read grant. Write grants and idle cycles leave it unchanged.
  - Wrap from ENGINES_CNT-1 to 0.
- Latency pipeline:
  - RAM_LATENCY stages, each holding {val, id[$clog2(ENGINES_CNT)]}.
  - Stage 0 loads {1, winner} on a read grant, else {0, x}.
  - rd_data_val_o[id] = last-stage val, i.e. exactly RAM_LATENCY cycles after the grant.
  - Writes never enter the pipeline.
- Throughput: one access per cycle; back-to-back reads from different or identical engines are allowed. Reads to an address written in the same or earlier cycle follow the RAM's read-after-write behaviour; no forwarding.
- rd_in_flight_o = OR of all stage val bits, registered and consistent with the pipeline contents.
- Requester protocol:
  - A requester drops req or changes address only after its gnt.
  - If req falls without a grant, it is ignored with no side effects.
- Reset mid-operation: pipeline is flushed, so no strobes are emitted for reads granted before reset. Pointer and counter return to their reset values.

Decomposition:
- hash_table package already supplies TABLE_ADDR_WIDTH and ram_data_t.
- Add to the package: an engine-id typedef sized by ENGINES_CNT (or use a local parameter if the package is not parameterisable), and the default STARVE_LIMIT constant.
- Sub-module: rr_arbiter (ENGINES_CNT requests, one-hot grant, pointer register, advance input). It is reusable for result collection.

Test Plan:
- Single request (N=3, L=2): rd_req_i=3'b010, addr 0x15 at cycle t -> rd_gnt_o=3'b010, ram_addr_o=0x15, ram_en_o=1, ram_we_o=0 at t; rd_data_val_o=3'b010 at t+2 only; rd_in_flight_o high t+1..t+2.
- All engines requesting continuously from reset -> grant order 0,1,2,0,1,2, one per cycle; strobes repeat the same order delayed 2 cycles; no idle cycles.
- Write pre-emption with starvation (STARVE_LIMIT=4): wr_req_i and rd_req_i[1] held high -> wr_gnt_o for 4 cycles, 5th cycle rd_gnt_o=3'b010, then writes resume.
- Pointer hold: grant engine 2, then 3 write-only cycles, then reqs 3'b111 -> engine 0 granted next (pointer stayed at 2 through the writes).
- Reset mid-flight: read granted at t, rst_i asserted at t+1 -> no rd_data_val_o at t+2; all outputs 0 while in reset.
- Dropped request: rd_req_i[0] pulses one cycle while a write wins -> no grant, no strobe, pointer unchanged.
